data_producer_gen: RTL

DATA_PRODUCER_GEN -- requirements
Module: data_producer_gen

---
 rtl/dp_pkg.sv | 59 +++++
 rtl/dp_lfsr_step.sv | 24 ++
 rtl/data_producer_gen.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/dp_pkg.sv
// Shared types for the data producer: pattern modes, FSM states and the
// per-width Galois LFSR tap masks used when DATA_PRODUCER_GEN_LFSR_EN is defined.
package dp_pkg;

  typedef enum logic [1:0] {
    MODE_INCR  = 2'd0,
    MODE_DECR  = 2'd1,
    MODE_CONST = 2'd2,
    MODE_LFSR  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int LFSR_MIN_W = 4;
  localparam int LFSR_MAX_W = 32;

  // Right-shifting Galois masks built from maximal-length polynomials.
  function automatic logic [31:0] lfsr_taps(input int w);
    logic [31:0] taps;
    case (w)
      4:       taps = 32'h0000_000C;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0030;
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_D008;
      17:      taps = 32'h0001_2000;
      18:      taps = 32'h0002_0400;
      19:      taps = 32'h0004_0023;
      20:      taps = 32'h0009_0000;
      21:      taps = 32'h0014_0000;
      22:      taps = 32'h0030_0000;
      23:      taps = 32'h0042_0000;
      24:      taps = 32'h00E1_0000;
      25:      taps = 32'h0120_0000;
      26:      taps = 32'h0200_0023;
      27:      taps = 32'h0400_0013;
      28:      taps = 32'h0900_0000;
      29:      taps = 32'h1400_0000;
      30:      taps = 32'h2000_0029;
      31:      taps = 32'h4800_0000;
      32:      taps = 32'h8020_0003;
      default: taps = 32'h0000_0000;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/dp_lfsr_step.sv
// One combinational step of a right-shifting Galois LFSR of width DATA_W.
module dp_lfsr_step
  import dp_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] state_i,
  output logic [DATA_W-1:0] next_o
);

  localparam logic [31:0]       TAPS_ALL = lfsr_taps(DATA_W);
  localparam logic [DATA_W-1:0] TAPS     = TAPS_ALL[DATA_W-1:0];

  // Shift right; fold the mask in when a one falls off the bottom.
  always_comb begin
    next_o = state_i >> 1;
    if (state_i[0]) begin
      next_o = next_o ^ TAPS;
    end else begin
      next_o = state_i >> 1;
    end
  end

endmodule

// File: rtl/data_producer_gen.sv
// Burst data pattern generator with valid/ready handshake (IDLE/SEND/GAP FSM).
// Define DATA_PRODUCER_GEN_LFSR_EN to build LFSR mode; otherwise mode 3 is INCR.
module data_producer_gen
  import dp_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int BURST_W = 8,
  parameter int GAP_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [DATA_W-1:0]  seed,
  input  logic [DATA_W-1:0]  step,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [GAP_W-1:0]   gap_len,
  output logic               valid_out,
  input  logic               ready_in,
  output logic [DATA_W-1:0]  data_out,
  output logic               last_out,
  output logic               busy
);

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic                arm_q;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   step_q, step_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [BURST_W-1:0]  cnt_q, cnt_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

  logic                transfer_s;
  logic [DATA_W-1:0]   seed_eff_s;
  logic [DATA_W-1:0]   adv_s;
  logic [BURST_W:0]    cnt_plus2_s;
  logic                burst_one_s;

  assign transfer_s  = valid_q & ready_in;
  assign cnt_plus2_s = {1'b0, cnt_q} + (BURST_W+1)'(2);
  assign burst_one_s = (burst_q == BURST_W'(1));

`ifdef DATA_PRODUCER_GEN_LFSR_EN
  logic [DATA_W-1:0] lfsr_next_s;

  dp_lfsr_step #(.DATA_W(DATA_W)) u_lfsr (
    .state_i (data_q),
    .next_o  (lfsr_next_s)
  );

  // An all-zero LFSR never leaves zero, so a zero seed is replaced.
  always_comb begin
    if ((mode == 2'd3) && (seed == '0)) begin
      seed_eff_s = '1;
    end else begin
      seed_eff_s = seed;
    end
  end
`else
  assign seed_eff_s = seed;
`endif

  // Next payload value for the latched pattern; all arithmetic wraps.
  always_comb begin
    adv_s = data_q + step_q;
    case (mode_q)
      MODE_INCR:  adv_s = data_q + step_q;
      MODE_DECR:  adv_s = data_q - step_q;
      MODE_CONST: adv_s = data_q;
`ifdef DATA_PRODUCER_GEN_LFSR_EN
      MODE_LFSR:  adv_s = lfsr_next_s;
`else
      MODE_LFSR:  adv_s = data_q + step_q;
`endif
      default:    adv_s = data_q + step_q;
    endcase
  end

  // FSM next state and registered-output next values.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    valid_d   = valid_q;
    last_d    = last_q;
    data_d    = data_q;
    step_d    = step_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        if (enable && arm_q) begin
          state_d = ST_SEND;
          mode_d  = mode_e'(mode);
          step_d  = step;
          burst_d = burst_len;
          gap_d   = gap_len;
          data_d  = seed_eff_s;
          cnt_d   = '0;
          valid_d = 1'b1;
          last_d  = (burst_len == BURST_W'(1));
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (transfer_s) begin
          data_d = adv_s;
          if (last_q) begin
            cnt_d = '0;
            if (gap_q != '0) begin
              state_d   = ST_GAP;
              gap_cnt_d = gap_q;
              valid_d   = 1'b0;
              last_d    = 1'b0;
            end else if (enable) begin
              valid_d = 1'b1;
              last_d  = burst_one_s;
            end else begin
              state_d = ST_IDLE;
              valid_d = 1'b0;
              last_d  = 1'b0;
            end
          end else if (burst_q == '0) begin
            // Continuous stream: enable is honoured beat by beat.
            if (enable) begin
              valid_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
              valid_d = 1'b0;
            end
          end else begin
            cnt_d  = cnt_q + BURST_W'(1);
            last_d = (cnt_plus2_s == {1'b0, burst_q});
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) begin
          gap_cnt_d = '0;
          if (enable) begin
            state_d = ST_SEND;
            valid_d = 1'b1;
            last_d  = burst_one_s;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // arm_q delays the first possible start by one cycle after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_INCR;
      arm_q     <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= '0;
      step_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      arm_q     <= 1'b1;
      valid_q   <= valid_d;
      last_q    <= last_d;
      data_q    <= data_d;
      step_q    <= step_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign last_out  = last_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
